// File: rtl/ten_eth_seek_arbiter_pkg.sv
// ten_eth_seek_arbiter_pkg: seek flags, MAC field offsets, request/result types and the MAC rule decode shared by the ToR lookup path
package ten_eth_seek_arbiter_pkg;
  typedef enum logic [1:0] {SEEK_LOCAL = 2'b00, SEEK_DIRECT = 2'b01, SEEK_BUFFER = 2'b10, SEEK_DROP = 2'b11} seek_flag_e;
  localparam int MAC_HEAD_LSB = 16;
  localparam int MAC_TOR_LSB = 8;
  localparam int MAC_PRT_LSB = 0;
  localparam int REQ_W = 52;
  typedef struct packed {
    logic [47:0] mac;
    logic [3:0]  id;
  } seek_req_t;
  typedef struct packed {
    logic [2:0] outport;
    seek_flag_e flag;
  } seek_res_t;
  function automatic seek_res_t seek_decode(input logic [47:0] mac, input logic [31:0] head, input logic [7:0] my_tor,
                                            input logic [7:0] host_num, input logic [2:0] uplink,
                                            input logic [2:0] snap_tor, input logic snap_valid);
    logic [7:0] tor;
    logic [7:0] prt;
    tor = mac[MAC_TOR_LSB +: 8];
    prt = mac[MAC_PRT_LSB +: 8];
    if (mac[MAC_HEAD_LSB +: 32] != head || tor > 8'd7) return seek_res_t'{3'd0, SEEK_DROP};
    if (tor == my_tor)
      return (prt >= 8'd1 && prt <= host_num) ? seek_res_t'{3'(prt - 8'd1), SEEK_LOCAL} : seek_res_t'{3'd0, SEEK_DROP};
    if (snap_valid && tor[2:0] == snap_tor) return seek_res_t'{uplink, SEEK_DIRECT};
    return seek_res_t'{tor[2:0], SEEK_BUFFER};
  endfunction
endpackage

// File: rtl/ten_eth_seek_arbiter_if.sv
// ten_eth_seek_arbiter_if: per-port check requests (mac/id/valid) in, per-port results (outport/flag/id/valid) out; master=RX ports, slave=arbiter
interface ten_eth_seek_arbiter_if #(parameter int PN = 2);
  logic [48*PN-1:0] i_check_mac;
  logic [4*PN-1:0]  i_check_id;
  logic [PN-1:0]    i_check_valid;
  logic [3*PN-1:0]  o_outport;
  logic [2*PN-1:0]  o_seek_flag;
  logic [4*PN-1:0]  o_check_id;
  logic [PN-1:0]    o_result_valid;
  modport master(output i_check_mac, i_check_id, i_check_valid, input o_outport, o_seek_flag, o_check_id, o_result_valid);
  modport slave(input i_check_mac, i_check_id, i_check_valid, output o_outport, o_seek_flag, o_check_id, o_result_valid);
endinterface

// File: rtl/seek_req_queue.sv
// seek_req_queue: P_DEPTH x P_WIDTH sync FIFO; in i_clk, i_rst (active-low), i_push, i_din, i_pop; out o_dout (head), o_full, o_empty
module seek_req_queue #(
  parameter int P_DEPTH = 2,
  parameter int P_WIDTH = 52
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [P_WIDTH-1:0] i_din,
  input  logic               i_pop,
  output logic [P_WIDTH-1:0] o_dout,
  output logic               o_full,
  output logic               o_empty
);
  localparam int AW = P_DEPTH > 1 ? $clog2(P_DEPTH) : 1;
  localparam int CW = $clog2(P_DEPTH + 1);
  logic [P_WIDTH-1:0] r_mem [P_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_wr, w_rd;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == CW'(P_DEPTH);
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);
  assign o_dout = r_mem[r_rp];
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wp] <= i_din;
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= w_wr ? (r_wp == AW'(P_DEPTH - 1) ? '0 : r_wp + AW'(1)) : r_wp;
      r_rp <= w_rd ? (r_rp == AW'(P_DEPTH - 1) ? '0 : r_rp + AW'(1)) : r_rp;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
endmodule

// File: rtl/ten_eth_seek_arbiter.sv
// ten_eth_seek_arbiter: RR outport lookup for PN RX ports; i_clk, i_rst (sync active-low), bus (requests in / results out), i_cur_connect_tor, i_connect_valid, o_drop_cnt
module ten_eth_seek_arbiter
  import ten_eth_seek_arbiter_pkg::*;
#(
  parameter int          P_PORT_NUM      = 2,
  parameter logic [31:0] P_MAC_HEAD      = 32'h8DBC5C4A,
  parameter int          P_MY_TOR_ID     = 0,
  parameter int          P_HOST_PORT_NUM = 2,
  parameter logic [2:0]  P_UPLINK_PORT   = 3'd7,
  parameter int          P_QDEPTH        = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  ten_eth_seek_arbiter_if.slave  bus,
  input  logic [2:0]             i_cur_connect_tor,
  input  logic                   i_connect_valid,
  output logic [15:0]            o_drop_cnt
);
  localparam int PW = P_PORT_NUM > 1 ? $clog2(P_PORT_NUM) : 1;
  seek_req_t r_in [P_PORT_NUM];
  seek_req_t w_head [P_PORT_NUM];
  seek_req_t r_s1_req;
  seek_res_t w_res;
  logic [P_PORT_NUM-1:0] r_in_valid, w_full, w_empty, w_pop, w_drop, r_result_valid;
  logic [PW-1:0] r_rr, w_gnt_idx, r_s1_port;
  logic w_gnt_valid, r_s1_valid, r_s1_cv;
  logic [2:0] r_s1_tor, w_drop_num;
  logic [16:0] w_drop_sum;
  logic [15:0] r_drop_cnt;
  logic [3*P_PORT_NUM-1:0] r_outport;
  logic [2*P_PORT_NUM-1:0] r_seek_flag;
  logic [4*P_PORT_NUM-1:0] r_check_id;
  always_ff @(posedge i_clk)
    for (int k = 0; k < P_PORT_NUM; k++) r_in[k] <= seek_req_t'({bus.i_check_mac[48*k +: 48], bus.i_check_id[4*k +: 4]});
  for (genvar k = 0; k < P_PORT_NUM; k++) begin : g_q
    seek_req_queue #(.P_DEPTH(P_QDEPTH), .P_WIDTH(REQ_W)) u_q (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (r_in_valid[k]),
      .i_din   (r_in[k]),
      .i_pop   (w_pop[k]),
      .o_dout  (w_head[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k])
    );
    assign w_drop[k] = r_in_valid[k] && w_full[k] && !w_pop[k];
  end
  // lowest non-empty index overall, overridden by the lowest non-empty index at or above the RR pointer
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx = '0;
    for (int i = P_PORT_NUM - 1; i >= 0; i--)
      if (!w_empty[i]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx = PW'(i);
      end
    for (int i = P_PORT_NUM - 1; i >= 0; i--)
      if (!w_empty[i] && PW'(i) >= r_rr) w_gnt_idx = PW'(i);
  end
  assign w_pop = w_gnt_valid ? P_PORT_NUM'(1) << w_gnt_idx : '0;
  always_comb begin
    w_drop_num = '0;
    for (int k = 0; k < P_PORT_NUM; k++) w_drop_num = w_drop_num + 3'(w_drop[k]);
  end
  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);
  assign w_res = seek_decode(r_s1_req.mac, P_MAC_HEAD, 8'(P_MY_TOR_ID), 8'(P_HOST_PORT_NUM), P_UPLINK_PORT, r_s1_tor, r_s1_cv);
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      r_in_valid <= '0;
      r_rr <= '0;
      r_s1_valid <= 1'b0;
      r_s1_port <= '0;
      r_s1_req <= '0;
      r_s1_tor <= '0;
      r_s1_cv <= 1'b0;
      r_outport <= '0;
      r_seek_flag <= '0;
      r_check_id <= '0;
      r_result_valid <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_in_valid <= bus.i_check_valid;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_s1_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_rr <= w_gnt_idx == PW'(P_PORT_NUM - 1) ? '0 : w_gnt_idx + PW'(1);
        r_s1_port <= w_gnt_idx;
        r_s1_req <= w_head[w_gnt_idx];
        r_s1_tor <= i_cur_connect_tor;
        r_s1_cv <= i_connect_valid;
      end
      r_result_valid <= r_s1_valid ? P_PORT_NUM'(1) << r_s1_port : '0;
      if (r_s1_valid) begin
        r_outport[3*r_s1_port +: 3] <= w_res.outport;
        r_seek_flag[2*r_s1_port +: 2] <= w_res.flag;
        r_check_id[4*r_s1_port +: 4] <= r_s1_req.id;
      end
    end
  assign bus.o_outport = r_outport;
  assign bus.o_seek_flag = r_seek_flag;
  assign bus.o_check_id = r_check_id;
  assign bus.o_result_valid = r_result_valid;
  assign o_drop_cnt = r_drop_cnt;
endmodule
